// File: rtl/boot_loader.sv
// Host-driven boot sequencer: decodes a UART byte protocol into debug-port word writes and CPU reset control.
// Define BOOT_LOADER_CSUM_EN to require a trailing 8-bit checksum byte on every load frame.
module boot_loader #(
    parameter int unsigned TIMEOUT_CYC   = 1000000,
    parameter bit          HOLD_AT_RESET = 1'b1,
    parameter logic [7:0]  ACK_BYTE      = 8'h06,
    parameter logic [7:0]  NAK_BYTE      = 8'h15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do,
    output logic        cpu_n_reset,
    output logic        err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_CNT   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
`ifdef BOOT_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd6;
`endif

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;

    logic [2:0]  state_r;
    logic [1:0]  idx_r;
    logic [15:0] words_left_r;
    logic [31:0] tmo_cnt_r;
    logic        collecting_s;
    logic        timeout_s;

`ifdef BOOT_LOADER_CSUM_EN
    logic [7:0] sum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction
`endif

    // States in which the host is expected to keep sending bytes
    always_comb begin
        collecting_s = 1'b0;
        case (state_r)
            S_ADDR, S_CNT, S_DATA: collecting_s = 1'b1;
`ifdef BOOT_LOADER_CSUM_EN
            S_CSUM:                collecting_s = 1'b1;
`endif
            default:               collecting_s = 1'b0;
        endcase
    end

    // Timeout fires on the TIMEOUT_CYC-th silent cycle; an arriving byte always wins
    always_comb begin
        timeout_s = 1'b0;
        if ((TIMEOUT_CYC != 32'd0) && collecting_s && !rx_valid) begin
            timeout_s = (tmo_cnt_r == (TIMEOUT_CYC - 32'd1));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Inter-byte silence counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 32'd0;
        end else if (!collecting_s || rx_valid || timeout_s) begin
            tmo_cnt_r <= 32'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end

`ifdef BOOT_LOADER_CSUM_EN
    // Running sum of every frame byte after the command byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= 8'h00;
        end else if (state_r == S_IDLE) begin
            sum_r <= 8'h00;
        end else if (collecting_s && rx_valid) begin
            sum_r <= csum_add(sum_r, rx_data);
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Frame sequencer driving every registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            idx_r        <= 2'd0;
            words_left_r <= 16'd0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            dbg_mem_op   <= 1'b0;
            dbg_wren     <= 4'h0;
            dbg_adr      <= 32'h0000_0000;
            dbg_do       <= 32'h0000_0000;
            cpu_n_reset  <= ~HOLD_AT_RESET;
            err          <= 1'b0;
        end else begin
            err      <= 1'b0;
            dbg_wren <= 4'h0;
            case (state_r)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_L: begin
                                cpu_n_reset <= 1'b0;
                                dbg_mem_op  <= 1'b1;
                                idx_r       <= 2'd0;
                                state_r     <= S_ADDR;
                            end
                            CMD_G:   cpu_n_reset <= 1'b1;
                            CMD_H:   cpu_n_reset <= 1'b0;
                            default: err <= 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        dbg_adr[{idx_r, 3'b000} +: 8] <= rx_data;
                        idx_r <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            // Words are always aligned; the host's low address bits are dropped
                            dbg_adr[1:0] <= 2'b00;
                            state_r      <= S_CNT;
                        end
                    end else if (timeout_s) begin
                        err      <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
                    end
                end
                S_CNT: begin
                    if (rx_valid) begin
                        if (idx_r == 2'd0) begin
                            words_left_r[7:0] <= rx_data;
                            idx_r             <= 2'd1;
                        end else begin
                            words_left_r <= {rx_data, words_left_r[7:0]};
                            idx_r        <= 2'd0;
                            if ({rx_data, words_left_r[7:0]} == 16'd0) begin
`ifdef BOOT_LOADER_CSUM_EN
                                state_r  <= S_CSUM;
`else
                                tx_data  <= ACK_BYTE;
                                tx_valid <= 1'b1;
                                state_r  <= S_ACK;
`endif
                            end else begin
                                state_r <= S_DATA;
                            end
                        end
                    end else if (timeout_s) begin
                        err      <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        dbg_do[{idx_r, 3'b000} +: 8] <= rx_data;
                        idx_r <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            dbg_wren <= 4'hF;
                            state_r  <= S_WRITE;
                        end
                    end else if (timeout_s) begin
                        err      <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
                    end
                end
                S_WRITE: begin
                    err          <= rx_valid;
                    dbg_adr      <= dbg_adr + 32'd4;
                    words_left_r <= words_left_r - 16'd1;
                    if (words_left_r == 16'd1) begin
`ifdef BOOT_LOADER_CSUM_EN
                        state_r  <= S_CSUM;
`else
                        tx_data  <= ACK_BYTE;
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
`endif
                    end else begin
                        state_r <= S_DATA;
                    end
                end
`ifdef BOOT_LOADER_CSUM_EN
                S_CSUM: begin
                    if (rx_valid) begin
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
                        if (csum_add(sum_r, rx_data) == 8'h00) begin
                            tx_data <= ACK_BYTE;
                        end else begin
                            tx_data <= NAK_BYTE;
                            err     <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        err      <= 1'b1;
                        tx_data  <= NAK_BYTE;
                        tx_valid <= 1'b1;
                        state_r  <= S_ACK;
                    end
                end
`endif
                S_ACK: begin
                    err <= rx_valid;
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        dbg_mem_op <= 1'b0;
                        state_r    <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid   <= 1'b0;
                    dbg_mem_op <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader; each task drives one scenario and checks it inline.
module tb_boot_loader;
    localparam int TMO = 40;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_do;
    logic        cpu_n_reset;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Event log filled by the monitor, read by the tests via snapshots
    int          wr_n = 0;
    logic [31:0] wr_adr [64];
    logic [31:0] wr_do  [64];
    logic [3:0]  wr_en  [64];
    int          err_n = 0;
    int          tx_n = 0;
    logic [7:0]  tx_last = 8'h00;
    int          cpu_hi_n = 0;
    logic [7:0]  tb_sum = 8'h00;

    logic [31:0] prog [6] = '{32'h000107b7, 32'h06100513, 32'h00a7a823,
                              32'h0147a503, 32'hfe050ee3, 32'hff1ff06f};

    boot_loader #(
        .TIMEOUT_CYC(TMO), .HOLD_AT_RESET(1'b1), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
        .cpu_n_reset(cpu_n_reset), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #2;
        if (dbg_wren != 4'h0 && wr_n < 64) begin
            wr_adr[wr_n] = dbg_adr;
            wr_do[wr_n]  = dbg_do;
            wr_en[wr_n]  = dbg_wren;
            wr_n = wr_n + 1;
        end
        if (err) err_n = err_n + 1;
        if (tx_valid && tx_ready) begin
            tx_last = tx_data;
            tx_n = tx_n + 1;
        end
        if (cpu_n_reset) cpu_hi_n = cpu_hi_n + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        tb_sum   = tb_sum + b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_frame(input logic [31:0] adr, input logic [15:0] n);
        send_byte(8'h4C);
        tb_sum = 8'h00;
        send_word(adr);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic end_frame;
        logic [7:0] c;
        c = 8'h00 - tb_sum;
`ifdef BOOT_LOADER_CSUM_EN
        send_byte(c);
`endif
    endtask

    task automatic wait_tx(input int base, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx_n != base) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_data !== 8'h00)  begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        checks++; if (tx_valid !== 1'b0)  begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        checks++; if (dbg_mem_op !== 1'b0) begin errors++; $display("FAIL rst_mem_op got %b exp 0", dbg_mem_op); end
        checks++; if (dbg_wren !== 4'h0 || dbg_adr !== 32'h0 || dbg_do !== 32'h0)
            begin errors++; $display("FAIL rst_dbg got %h/%h/%h exp 0/0/0", dbg_wren, dbg_adr, dbg_do); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL rst_cpu got %b exp 0", cpu_n_reset); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_load;
        int wb, tb, cb, eb;
        wb = wr_n; tb = tx_n; cb = cpu_hi_n; eb = err_n;
        start_frame(32'h0002_0000, 16'd6);
        checks++; if (dbg_mem_op !== 1'b1) begin errors++; $display("FAIL load_mem_op got %b exp 1", dbg_mem_op); end
        for (int i = 0; i < 6; i++) send_word(prog[i]);
        end_frame();
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 6) begin errors++; $display("FAIL load_nwr got %0d exp 6", wr_n - wb); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_adr[wb+i] !== 32'h0002_0000 + 32'(4*i) || wr_do[wb+i] !== prog[i] || wr_en[wb+i] !== 4'hF) begin
                errors++;
                $display("FAIL load_wr%0d got %h %h %h exp %h %h f", i, wr_adr[wb+i], wr_do[wb+i], wr_en[wb+i],
                         32'h0002_0000 + 32'(4*i), prog[i]);
            end
        end
        checks++; if (tx_n - tb !== 1 || tx_last !== 8'h06) begin errors++; $display("FAIL load_ack got n=%0d %h exp n=1 06", tx_n - tb, tx_last); end
        checks++; if (cpu_hi_n !== cb) begin errors++; $display("FAIL load_cpu got %0d high cycles exp 0", cpu_hi_n - cb); end
        checks++; if (err_n !== eb) begin errors++; $display("FAIL load_err got %0d exp 0", err_n - eb); end
    endtask

    task automatic test_go_halt;
        @(negedge clk); rx_data = 8'h47; rx_valid = 1'b1;
        checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL go_before got %b exp 0", cpu_n_reset); end
        @(negedge clk); rx_valid = 1'b0;
        checks++; if (cpu_n_reset !== 1'b1 || dbg_mem_op !== 1'b0)
            begin errors++; $display("FAIL go_after got cpu=%b mem=%b exp 1 0", cpu_n_reset, dbg_mem_op); end
        @(negedge clk); rx_data = 8'h48; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        checks++; if (cpu_n_reset !== 1'b0) begin errors++; $display("FAIL halt got %b exp 0", cpu_n_reset); end
    endtask

    task automatic test_wrap;
        int wb, tb;
        wb = wr_n; tb = tx_n;
        start_frame(32'hFFFF_FFFC, 16'd2);
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        end_frame();
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 2 || wr_adr[wb] !== 32'hFFFF_FFFC || wr_adr[wb+1] !== 32'h0000_0000)
            begin errors++; $display("FAIL wrap_adr got n=%0d %h %h exp n=2 fffffffc 00000000", wr_n - wb, wr_adr[wb], wr_adr[wb+1]); end
        checks++; if (wr_do[wb] !== 32'hDEAD_BEEF || wr_do[wb+1] !== 32'h1234_5678)
            begin errors++; $display("FAIL wrap_do got %h %h exp deadbeef 12345678", wr_do[wb], wr_do[wb+1]); end
        checks++; if (tx_last !== 8'h06) begin errors++; $display("FAIL wrap_ack got %h exp 06", tx_last); end
    endtask

    task automatic test_timeout;
        int wb, tb, eb;
        wb = wr_n; tb = tx_n; eb = err_n;
        start_frame(32'h0002_0000, 16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO - 5) @(negedge clk);
        checks++; if (err_n !== eb || tx_n !== tb) begin errors++; $display("FAIL tmo_early got err=%0d tx=%0d exp 0 0", err_n - eb, tx_n - tb); end
        repeat (7) @(negedge clk);
        checks++; if (err_n - eb !== 1) begin errors++; $display("FAIL tmo_err got %0d exp 1", err_n - eb); end
        checks++; if (tx_n - tb !== 1 || tx_last !== 8'h15) begin errors++; $display("FAIL tmo_nak got n=%0d %h exp n=1 15", tx_n - tb, tx_last); end
        checks++; if (wr_n !== wb || dbg_mem_op !== 1'b0) begin errors++; $display("FAIL tmo_idle got wr=%0d mem=%b exp 0 0", wr_n - wb, dbg_mem_op); end
        // Follow-up frame with unaligned address bytes: low bits must be dropped
        wb = wr_n; tb = tx_n;
        start_frame(32'h0000_0103, 16'd1);
        send_word(32'hCAFE_F00D);
        end_frame();
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 1 || wr_adr[wb] !== 32'h0000_0100 || wr_do[wb] !== 32'hCAFE_F00D)
            begin errors++; $display("FAIL tmo_next got n=%0d %h %h exp n=1 00000100 cafef00d", wr_n - wb, wr_adr[wb], wr_do[wb]); end
        checks++; if (tx_last !== 8'h06) begin errors++; $display("FAIL tmo_next_ack got %h exp 06", tx_last); end
    endtask

    task automatic test_bad_idle_and_hold;
        int wb, tb, eb, bad;
        wb = wr_n; tb = tx_n; eb = err_n; bad = 0;
        send_byte(8'h5A);
        repeat (2) @(negedge clk);
        checks++; if (err_n - eb !== 1 || dbg_mem_op !== 1'b0 || tx_valid !== 1'b0)
            begin errors++; $display("FAIL bad_idle got err=%0d mem=%b txv=%b exp 1 0 0", err_n - eb, dbg_mem_op, tx_valid); end
        tx_ready = 1'b0;
        start_frame(32'h0002_0000, 16'd0);
        end_frame();
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0 || tx_n !== tb) begin errors++; $display("FAIL hold_txv got bad=%0d tx=%0d exp 0 0", bad, tx_n - tb); end
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || tx_n - tb !== 1 || tx_last !== 8'h06)
            begin errors++; $display("FAIL hold_done got txv=%b n=%0d %h exp 0 1 06", tx_valid, tx_n - tb, tx_last); end
        checks++; if (wr_n !== wb) begin errors++; $display("FAIL n0_nowr got %0d exp 0", wr_n - wb); end
    endtask

    task automatic test_drop_in_write;
        int wb, tb, eb;
        wb = wr_n; tb = tx_n; eb = err_n;
        start_frame(32'h0000_1000, 16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        @(negedge clk); rx_data = 8'h04; rx_valid = 1'b1;
        @(negedge clk); rx_data = 8'hEE; rx_valid = 1'b1;
        @(negedge clk); rx_valid = 1'b0;
        end_frame();
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 1 || wr_adr[wb] !== 32'h0000_1000 || wr_do[wb] !== 32'h0403_0201)
            begin errors++; $display("FAIL drop_wr got n=%0d %h %h exp n=1 00001000 04030201", wr_n - wb, wr_adr[wb], wr_do[wb]); end
        checks++; if (err_n - eb !== 1 || tx_last !== 8'h06)
            begin errors++; $display("FAIL drop_err got err=%0d %h exp 1 06", err_n - eb, tx_last); end
    endtask

    task automatic test_reset_midframe;
        int wb, tb;
        send_byte(8'h4C);
        send_byte(8'h34);
        send_byte(8'h12);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        checks++; if (dbg_mem_op !== 1'b0 || dbg_adr !== 32'h0 || cpu_n_reset !== 1'b0 || tx_valid !== 1'b0)
            begin errors++; $display("FAIL midrst got mem=%b adr=%h cpu=%b txv=%b exp 0 0 0 0", dbg_mem_op, dbg_adr, cpu_n_reset, tx_valid); end
        @(negedge clk); reset = 1'b0;
        wb = wr_n; tb = tx_n;
        start_frame(32'h0000_0200, 16'd1);
        send_word(32'h5555_AAAA);
        end_frame();
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 1 || wr_adr[wb] !== 32'h0000_0200 || wr_do[wb] !== 32'h5555_AAAA || tx_last !== 8'h06)
            begin errors++; $display("FAIL midrst_next got n=%0d %h %h %h exp n=1 00000200 5555aaaa 06", wr_n - wb, wr_adr[wb], wr_do[wb], tx_last); end
    endtask

`ifdef BOOT_LOADER_CSUM_EN
    task automatic test_csum;
        int wb, tb, eb;
        // Frame bytes 00 00 02 00 01 00 44 33 22 11 sum to AD, so 53 closes the sum to 00
        wb = wr_n; tb = tx_n; eb = err_n;
        start_frame(32'h0002_0000, 16'd1);
        send_word(32'h1122_3344);
        send_byte(8'h53);
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 1 || wr_do[wb] !== 32'h1122_3344 || tx_last !== 8'h06 || err_n !== eb)
            begin errors++; $display("FAIL csum_ok got n=%0d %h %h err=%0d exp 1 11223344 06 0", wr_n - wb, wr_do[wb], tx_last, err_n - eb); end
        wb = wr_n; tb = tx_n; eb = err_n;
        start_frame(32'h0002_0000, 16'd1);
        send_word(32'h1122_3344);
        send_byte(8'h00);
        wait_tx(tb, 20);
        checks++; if (wr_n - wb !== 1 || tx_last !== 8'h15 || err_n - eb !== 1)
            begin errors++; $display("FAIL csum_bad got n=%0d %h err=%0d exp 1 15 1", wr_n - wb, tx_last, err_n - eb); end
    endtask
`endif

    initial begin
        rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; reset = 1'b1;
        test_reset();
        test_load();
        test_go_halt();
        test_wrap();
        test_timeout();
        test_bad_idle_and_hold();
        test_drop_in_write();
        test_reset_midframe();
`ifdef BOOT_LOADER_CSUM_EN
        test_csum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
